// File: rtl/uart_tx.sv
// Asynchronous serial transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// A one-byte holding register lets the next byte queue while the current frame is on the line.
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [7:0] data_tx_nios,
    input  logic       tx_start,
    input  logic [7:0] usr_options,
    input  logic       cts_remote_n,
    output logic       serial_out,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    hold_data;
    logic [7:0]    shift, shift_nxt;
    logic          hold_full;
    logic          cts_meta, cts_sync;
    logic          par_en, par_bit, stop2, stop_second;
    logic          bit_end, stop_end, load, accept;
    logic          line_nxt;
    logic          unused_opts;

    assign unused_opts = ^usr_options[7:3];

    assign bit_end  = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign stop_end = (state == STOP) && bit_end && (!stop2 || stop_second);
    // A frame may begin from IDLE or straight out of the final stop bit (no idle gap).
    assign load     = hold_full && !cts_sync && ((state == IDLE) || stop_end);
    assign accept   = tx_start && !hold_full;

    assign tx_ready = !hold_full;
    assign tx_busy  = (state != IDLE);
    assign tx_done  = stop_end;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = START;
            START:   if (bit_end) state_nxt = DATA;
            DATA:    if (bit_end && (bit_idx == 3'd7)) state_nxt = par_en ? PARITY : STOP;
            PARITY:  if (bit_end) state_nxt = STOP;
            STOP:    if (stop_end) state_nxt = load ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Line level is computed from the next state so serial_out itself is a plain flop.
    always_comb begin
        shift_nxt = shift;
        if (load)
            shift_nxt = hold_data;
        else if ((state == DATA) && bit_end)
            shift_nxt = {1'b0, shift[7:1]};
        line_nxt = 1'b1;
        case (state_nxt)
            START:   line_nxt = 1'b0;
            DATA:    line_nxt = shift_nxt[0];
            PARITY:  line_nxt = par_bit;
            default: line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            cts_meta    <= 1'b1;
            cts_sync    <= 1'b1;
            serial_out  <= 1'b1;
            shift       <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            par_en      <= 1'b0;
            par_bit     <= 1'b0;
            stop2       <= 1'b0;
            stop_second <= 1'b0;
            baud_cnt    <= '0;
            bit_idx     <= '0;
        end else begin
            cts_meta   <= cts_remote_n;
            cts_sync   <= cts_meta;
            serial_out <= line_nxt;
            shift      <= shift_nxt;

            if (load) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
                hold_data <= data_tx_nios;
            end

            // Frame format is frozen for the whole frame at load time.
            if (load) begin
                par_en  <= usr_options[0] ^ usr_options[1];
                par_bit <= (^hold_data) ^ (usr_options[1:0] == 2'b10);
                stop2   <= usr_options[2];
            end

            if ((state_nxt == IDLE) || (state_nxt != state) || bit_end)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + CW'(1);

            if (load)
                bit_idx <= '0;
            else if ((state == DATA) && bit_end)
                bit_idx <= bit_idx + 3'd1;

            stop_second <= (state == STOP) && (stop_second || bit_end);
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames, hand sequences for queueing/CTS/reset,
// and random frames compared against a bit-list model of the frame format.
module tb_uart_tx;
    localparam int CPB = 4;

    logic       sys_clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_tx_nios = '0;
    logic       tx_start = 1'b0;
    logic [7:0] usr_options = '0;
    logic       cts_remote_n = 1'b0;
    logic       serial_out, tx_ready, tx_busy, tx_done;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .sys_clk(sys_clk), .reset(reset), .data_tx_nios(data_tx_nios), .tx_start(tx_start),
        .usr_options(usr_options), .cts_remote_n(cts_remote_n), .serial_out(serial_out),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    typedef struct {
        logic [7:0] opts;
        logic [7:0] data;
        int         exp_len;
        int         exp_par;
    } vec_t;

    vec_t vecs[8];
    logic exp_q[$];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line level per clock for one frame, appended to exp_q.
    function automatic void append_frame(input logic [7:0] d, input logic [7:0] o);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (o[1:0] == 2'b01)      bits.push_back(^d);
        else if (o[1:0] == 2'b10) bits.push_back(~^d);
        bits.push_back(1'b1);
        if (o[2]) bits.push_back(1'b1);
        foreach (bits[i])
            for (int k = 0; k < CPB; k++) exp_q.push_back(bits[i]);
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (tx_ready !== 1'b1 && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        if (tx_ready !== 1'b1) chk("ready_timeout", tx_ready, 1'b1);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [7:0] o, input int exp_len, input int exp_par);
        int len, done_at, done_cnt;
        exp_q.delete();
        append_frame(d, o);
        len = exp_q.size();
        wait_ready();
        @(negedge sys_clk);
        data_tx_nios = d; usr_options = o; tx_start = 1'b1;
        @(negedge sys_clk);
        tx_start = 1'b0;
        chk("accept_ready_low", tx_ready, 1'b0);
        chk("accept_line_idle", serial_out, 1'b1);
        done_at = 0; done_cnt = 0;
        for (int c = 1; c <= len; c++) begin
            @(negedge sys_clk);
            chk("frame_line", serial_out, exp_q[c-1]);
            chk("frame_busy", tx_busy, 1'b1);
            if (tx_done === 1'b1) begin done_cnt++; done_at = c; end
            if (exp_par >= 0 && c == 9*CPB + CPB/2) chk("parity_bit", serial_out, exp_par[0]);
            if (c == 1) usr_options = 8'($urandom);
        end
        chk_int("done_count", done_cnt, 1);
        chk_int("frame_len", done_at, (exp_len > 0) ? exp_len : len);
        @(negedge sys_clk);
        chk("post_line", serial_out, 1'b1);
        chk("post_busy", tx_busy, 1'b0);
        chk("post_done", tx_done, 1'b0);
        chk("post_ready", tx_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd, ro;
        int f;
        vecs[0] = '{8'h00, 8'h55, 40, -1};
        vecs[1] = '{8'h01, 8'h07, 44,  1};
        vecs[2] = '{8'h02, 8'h07, 44,  0};
        vecs[3] = '{8'h03, 8'h07, 40, -1};
        vecs[4] = '{8'h04, 8'hFF, 44, -1};
        vecs[5] = '{8'h05, 8'h00, 48,  0};
        vecs[6] = '{8'h06, 8'h80, 48,  0};
        vecs[7] = '{8'hF9, 8'h01, 44,  1};

        repeat (3) @(negedge sys_clk);
        chk("reset_line", serial_out, 1'b1);
        chk("reset_ready", tx_ready, 1'b1);
        chk("reset_busy", tx_busy, 1'b0);
        chk("reset_done", tx_done, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge sys_clk);

        foreach (vecs[i]) run_frame(vecs[i].data, vecs[i].opts, vecs[i].exp_len, vecs[i].exp_par);

        // Back-to-back frames; a strobe while the holding register is full is dropped.
        exp_q.delete();
        append_frame(8'hA5, 8'h00);
        append_frame(8'h3C, 8'h00);
        wait_ready();
        @(negedge sys_clk);
        usr_options = 8'h00; data_tx_nios = 8'hA5; tx_start = 1'b1;
        @(negedge sys_clk);
        tx_start = 1'b0;
        for (int c = 1; c <= 90; c++) begin
            @(negedge sys_clk);
            chk("b2b_line", serial_out, (c <= 80) ? exp_q[c-1] : 1'b1);
            chk("b2b_busy", tx_busy, c <= 80);
            chk("b2b_done", tx_done, (c == 40) || (c == 80));
            if (c == 1) begin
                chk("b2b_ready_up", tx_ready, 1'b1);
                data_tx_nios = 8'h3C; tx_start = 1'b1;
            end else if (c == 2) begin
                chk("b2b_ready_down", tx_ready, 1'b0);
                data_tx_nios = 8'h99; tx_start = 1'b1;
            end else if (c == 3) begin
                tx_start = 1'b0;
            end
        end

        // CTS gating: frame held until synchronized CTS goes low, then unaffected by CTS.
        cts_remote_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        exp_q.delete();
        append_frame(8'h12, 8'h00);
        data_tx_nios = 8'h12; tx_start = 1'b1;
        @(negedge sys_clk);
        tx_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            chk("cts_hold_line", serial_out, 1'b1);
            chk("cts_hold_ready", tx_ready, 1'b0);
            chk("cts_hold_busy", tx_busy, 1'b0);
        end
        cts_remote_n = 1'b0;
        for (int c = 1; c <= 42; c++) begin
            @(negedge sys_clk);
            if (c < 3) begin
                chk("cts_sync_line", serial_out, 1'b1);
                chk("cts_sync_busy", tx_busy, 1'b0);
            end else begin
                f = c - 2;
                chk("cts_frame_line", serial_out, exp_q[f-1]);
                chk("cts_frame_busy", tx_busy, 1'b1);
                chk("cts_frame_done", tx_done, f == 40);
                if (f == 10) cts_remote_n = 1'b1;
            end
        end
        @(negedge sys_clk);
        chk("cts_end_line", serial_out, 1'b1);
        chk("cts_end_busy", tx_busy, 1'b0);
        cts_remote_n = 1'b0;
        repeat (3) @(negedge sys_clk);

        // Reset during data bit 3 of 0xF0 (bit 3 is 0, so the line is low when reset hits).
        wait_ready();
        @(negedge sys_clk);
        usr_options = 8'h00; data_tx_nios = 8'hF0; tx_start = 1'b1;
        @(negedge sys_clk);
        tx_start = 1'b0;
        repeat (4*CPB + 2) @(negedge sys_clk);
        chk("pre_reset_line", serial_out, 1'b0);
        chk("pre_reset_busy", tx_busy, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("async_reset_line", serial_out, 1'b1);
        chk("async_reset_ready", tx_ready, 1'b1);
        chk("async_reset_busy", tx_busy, 1'b0);
        chk("async_reset_done", tx_done, 1'b0);
        repeat (2) begin
            @(negedge sys_clk);
            chk("in_reset_done", tx_done, 1'b0);
            chk("in_reset_line", serial_out, 1'b1);
        end
        reset = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("post_reset_line", serial_out, 1'b1);
        chk("post_reset_busy", tx_busy, 1'b0);
        run_frame(8'h81, 8'h00, 40, -1);

        for (int i = 0; i < 20; i++) begin
            rd = 8'($urandom);
            ro = 8'($urandom);
            run_frame(rd, ro, 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Transmit half of the RS-232 link. The existing receiver handles serial_in, cts and the byte/parity path toward the Nios.
- This block takes a byte written by the Nios and shifts it out on serial_out as a standard asynchronous frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Frame format comes from the same usr_options register the receiver uses.
- A one-byte holding register lets the Nios queue the next byte while the current one is on the line.

Parameters:
- CLKS_PER_BIT, 5208, sys_clk cycles per bit (50 MHz / 9600 baud); must be >= 2.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_tx_nios  in  8  byte to transmit.
- tx_start  in  1  write strobe from Nios; sampled each cycle.
- usr_options  in  8  frame config: [1:0] parity (00 none, 01 even, 10 odd, 11 = none); [2] stop bits (0 = one, 1 = two); [7:3] ignored.
- cts_remote_n  in  1  remote clear-to-send, active-low, asynchronous to sys_clk.
- serial_out  out  1  TX line, idle high.
- tx_ready  out  1  holding register empty; tx_start is accepted only while high.
- tx_busy  out  1  frame in progress (FSM not IDLE).
- tx_done  out  1  one-cycle pulse at end of each frame.

Behaviour:
- Reset (asserted low, immediate):
  - serial_out=1, tx_ready=1, tx_busy=0, tx_done=0.
  - FSM=IDLE; holding register, counters and CTS synchronizer cleared (synchronizer cleared to 1 = not clear).
  - Reset mid-frame aborts the frame; the line returns high at once, with no partial stop bit.
- Accept:
  - If tx_start=1 and tx_ready=1 at a rising edge, data_tx_nios is copied into the holding register and tx_ready drops at that edge.
  - If tx_start=1 while tx_ready=0, the strobe is ignored: no overwrite, no error flag.
- CTS: cts_remote_n passes through a 2-FF synchronizer. The synchronized value is checked only when a frame is about to start. Changes mid-frame are ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when holding is full and synchronized CTS=0. At that edge:
    - holding moves to the shift register; tx_ready rises.
    - usr_options is latched; later changes don't affect this frame.
    - Parity is precomputed: even = XOR of the 8 data bits; odd = its inverse.
  - START: serial_out=0 for CLKS_PER_BIT cycles, then -> DATA.
  - DATA: bits 0..7, LSB first, each CLKS_PER_BIT cycles. A 3-bit index counter wraps 7 -> 0.
    - After bit 7, go to PARITY if parity is enabled, else to STOP.
  - PARITY: parity bit for CLKS_PER_BIT cycles, then -> STOP.
  - STOP: serial_out=1 for CLKS_PER_BIT cycles (one stop bit) or 2*CLKS_PER_BIT (two stop bits).
  - End of STOP:
    - tx_done=1 for exactly one cycle.
    - If holding is full and synchronized CTS=0, go directly to START with the same load actions as IDLE->START, so there is no idle gap between frames.
    - Otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and is reset on every state entry. Every bit is exactly CLKS_PER_BIT cycles; the frame length is fixed at (10 + parity + extra stop) * CLKS_PER_BIT cycles.
- Latency: with CTS already synchronized low and the FSM idle, tx_start sampled at edge N gives holding loaded at N, START entered at N+1, and serial_out falling right after edge N+1.
- tx_busy=1 in every state except IDLE. It stays high through a back-to-back STOP->START transition.
- tx_start in the same cycle holding transfers to shift: tx_ready is low in that cycle, so the strobe is ignored. The Nios must poll tx_ready.
- serial_out is driven directly from a register (glitch-free).

Test Plan:
- CLKS_PER_BIT=4, options 0x00, send 0x55 with CTS low -> serial_out 0,1,0,1,0,1,0,1,0,1, each 4 cycles. Falling edge 1 cycle after the accept edge; tx_done pulses once at cycle 40; tx_busy high for 40 cycles.
- Options 0x01 (even), byte 0x07 -> parity bit 1. Options 0x02 (odd), byte 0x07 -> parity bit 0. Options 0x03, byte 0x07 -> no parity bit, 40-cycle frame.
- Options 0x04, byte 0xFF -> two stop bits; frame 44 cycles; tx_done at end of second stop bit.
- Queue 0xA5, then 0x3C as soon as tx_ready rises -> second start bit begins on the cycle immediately after the first frame's last stop bit. A third strobe issued while tx_ready=0 is dropped (only two frames on the line).
- cts_remote_n=1, write 0x12 -> serial_out stays high and tx_ready=0. Drop CTS to 0 -> start bit 3 cycles later (2 sync + 1). Raising CTS mid-frame does not stop the frame.
- Assert reset during DATA bit 3 -> serial_out=1 asynchronously; tx_ready=1, tx_busy=0, no tx_done. After release, a new 0x81 frame transmits correctly.
